laplace4_add_sequencer: RTL and testbench



---
 rtl/laplace4_add_sequencer.sv | 124 ++++++++++++
 tb/tb_laplace4_add_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/laplace4_add_sequencer.sv
// Computes 4*C - N - E - S - W per window using one external 8-bit adder over eight byte passes.
// Define CLAMP_EN to clamp res_data to the 0..255 pixel range instead of raw two's complement.
module laplace4_add_sequencer #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned RES_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] pix_c,
   input  logic [PIX_W-1:0] pix_n,
   input  logic [PIX_W-1:0] pix_e,
   input  logic [PIX_W-1:0] pix_s,
   input  logic [PIX_W-1:0] pix_w,
   output logic [PIX_W-1:0] add_a,
   output logic [PIX_W-1:0] add_b,
   output logic             add_cin,
   output logic             add_en,
   input  logic [PIX_W-1:0] add_s,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] res_data
);

   typedef enum logic [1:0] {StIdle, StAddLo, StAddHi, StDone} state_e;

   state_e                 state_q, state_d;
   logic [RES_W-1:0]       acc_q, acc_d;
   logic [1:0]             idx_q, idx_d;
   logic                   carry_q, carry_d;
   logic [3:0][PIX_W-1:0]  op_q, op_d;
   logic [RES_W-1:0]       res_value;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      op_d      = op_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      add_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               op_d    = {pix_w, pix_s, pix_e, pix_n};
               acc_d   = {{(RES_W-PIX_W-2){1'b0}}, pix_c, 2'b00};
               idx_d   = '0;
               state_d = StAddLo;
            end
         end
         StAddLo: begin
            // Subtraction as A + ~B + 1; the high pass carries on with ~B sign-extended.
            add_en            = 1'b1;
            add_a             = acc_q[PIX_W-1:0];
            add_b             = ~op_q[idx_q];
            add_cin           = 1'b1;
            acc_d[PIX_W-1:0]  = add_s;
            carry_d           = add_cout;
            state_d           = StAddHi;
         end
         StAddHi: begin
            add_en                = 1'b1;
            add_a                 = acc_q[RES_W-1:PIX_W];
            add_b                 = '1;
            add_cin               = carry_q;
            acc_d[RES_W-1:PIX_W]  = add_s;
            if (idx_q == 2'd3) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = StAddLo;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef CLAMP_EN
   always_comb begin
      if (acc_q[RES_W-1]) begin
         res_value = '0;
      end else if (|acc_q[RES_W-2:PIX_W]) begin
         res_value = {{(RES_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};
      end else begin
         res_value = {{(RES_W-PIX_W){1'b0}}, acc_q[PIX_W-1:0]};
      end
   end
`else
   assign res_value = acc_q;
`endif

   // Only present the accumulator once it holds a finished result.
   assign res_data = (state_q == StDone) ? res_value : '0;

endmodule

// File: tb/tb_laplace4_add_sequencer.sv
// Directed bench for laplace4_add_sequencer with an exact 8-bit adder model on the adder port.
module tb_laplace4_add_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  pix_c, pix_n, pix_e, pix_s, pix_w;
   logic [7:0]  add_a, add_b, add_s;
   logic        add_cin, add_en, add_cout;
   logic        out_valid, out_ready;
   logic [15:0] res_data;

   int n_vec;
   int n_miss;

   laplace4_add_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pix_c     (pix_c),
      .pix_n     (pix_n),
      .pix_e     (pix_e),
      .pix_s     (pix_s),
      .pix_w     (pix_w),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_en    (add_en),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_data  (res_data)
   );

   logic [8:0] sum9;
   assign sum9 = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
   assign add_s    = sum9[7:0];
   assign add_cout = sum9[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_res_data"},  32'(res_data),  32'd0);
      check_eq({tag, "_add_a"},     32'(add_a),     32'd0);
      check_eq({tag, "_add_b"},     32'(add_b),     32'd0);
      check_eq({tag, "_add_cin"},   32'(add_cin),   32'd0);
      check_eq({tag, "_add_en"},    32'(add_en),    32'd0);
   endtask

   // Accept edge counts as edge 1; out_valid must first appear after edge 9.
   task automatic run_window(input string tag, input logic [7:0] c, n, e, s, w,
                             input logic [15:0] exp, input int hold, input bit chk_p1);
      int cycles;
      pix_c = c; pix_n = n; pix_e = e; pix_s = s; pix_w = w;
      out_ready = (hold == 0);
      check_eq({tag, "_ready_before"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cycles = 1;
      if (chk_p1) begin
         check_eq({tag, "_p1_a"},   32'(add_a),   32'h90);
         check_eq({tag, "_p1_b"},   32'(add_b),   32'hEB);
         check_eq({tag, "_p1_cin"}, 32'(add_cin), 32'd1);
         check_eq({tag, "_p1_en"},  32'(add_en),  32'd1);
      end
      while (!out_valid && cycles < 20) begin
         check_eq({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
         tick();
         cycles++;
      end
      check_eq({tag, "_latency"}, 32'(cycles), 32'd9);
      check_eq({tag, "_res"}, 32'(res_data), 32'(exp));
      check_eq({tag, "_done_ready"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         pix_c = 8'd1;
         tick();
         check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check_eq({tag, "_hold_res"},   32'(res_data),  32'(exp));
         check_eq({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_eq({tag, "_back_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_back_ready"}, 32'(in_ready),  32'd1);
   endtask

   logic [15:0] exp_big, exp_neg, exp_mix, exp_after;

   initial begin
      n_vec = 0;
      n_miss = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      {pix_c, pix_n, pix_e, pix_s, pix_w} = '0;
`ifdef CLAMP_EN
      exp_big = 16'h00FF; exp_neg = 16'h0000; exp_mix = 16'h00FF; exp_after = 16'h0064;
`else
      exp_big = 16'h03FC; exp_neg = 16'hFC04; exp_mix = 16'h0104; exp_after = 16'h0064;
`endif
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check_idle_outputs("reset");

      run_window("flat", 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 16'h0000, 0, 1'b0);
      run_window("max",  8'd255, 8'd0, 8'd0, 8'd0, 8'd0, exp_big, 0, 1'b0);
      run_window("min",  8'd0, 8'd255, 8'd255, 8'd255, 8'd255, exp_neg, 0, 1'b0);
      run_window("mix",  8'd100, 8'd20, 8'd30, 8'd40, 8'd50, exp_mix, 0, 1'b1);
      run_window("bp",   8'd100, 8'd20, 8'd30, 8'd40, 8'd50, exp_mix, 5, 1'b0);

      // Abort during the high-byte pass of the third operand (edge 6 after accept).
      pix_c = 8'd200; pix_n = 8'd1; pix_e = 8'd2; pix_s = 8'd3; pix_w = 8'd4;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check_eq("rst_pre_en", 32'(add_en), 32'd1);
      check_eq("rst_pre_b",  32'(add_b),  32'hFF);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_idle_outputs("midrst");
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("midrst_no_valid", 32'(out_valid), 32'd0);
      end
      run_window("after", 8'd50, 8'd10, 8'd20, 8'd30, 8'd40, exp_after, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
